gnr_cycle_ctrl: RTL and testbench
=================================

GNR_CYCLE_CTRL -- requirements
Module: gnr_cycle_ctrl

Interface
REQ-001 SHALL have parameter N_NODES, default 16, number of network nodes driven.
REQ-002 SHALL have parameter CNT_W, default 16, width of step/period counters.
REQ-003 SHALL have parameter MAX_STEPS, default 16'hFFFF, RUN/PERIOD cycle limit before timeout.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-007 init_vec  in  N_NODES  initial network state, captured when start is accepted.
REQ-008 s0_vec  in  N_NODES  concatenated slow-trajectory node states, bit i = node i.
REQ-009 s1_vec  in  N_NODES  concatenated fast-trajectory node states.
REQ-010 reset_nos  out  1  node load strobe, broadcast.
REQ-011 init_state  out  N_NODES  per-node load value, bit i to node i.
REQ-012 start_s0 / start_s1  out  1 each  advance enables for slow/fast trajectories.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); timeout  out  1.
REQ-014 meet_steps  out  CNT_W  slow-trajectory steps to meeting point; period  out  CNT_W  attractor length.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, PERIOD, DONE.
REQ-016 IDLE: start=1 SHALL capture init_vec into init_state, clear counters/timeout, go LOAD; start outside IDLE SHALL be ignored.
REQ-017 LOAD (exactly one cycle): reset_nos=1, start_s0=start_s1=0; next RUN, run counter t=0.
REQ-018 RUN: nodes' slow path advances on every second enabled cycle, so after t RUN cycles s0 = t/2 steps, s1 = t steps.
REQ-019 RUN: start_s0=start_s1=1 combinationally each cycle, except the match cycle, where both SHALL be 0.
REQ-020 Match: t even, t>0, s0_vec==s1_vec; SHALL load meet_steps=t/2, go PERIOD with period counter p=0.
REQ-021 PERIOD: start_s0=0, start_s1=1 each cycle except the match cycle (start_s1=0); p increments per cycle.
REQ-022 PERIOD match: p>=1 and s1_vec==s0_vec; SHALL load period=p, go DONE.
REQ-023 Fixed point SHALL yield period=1.
REQ-024 If t or p reaches MAX_STEPS without match, SHALL set timeout=1, deassert enables that cycle, go DONE; period/meet_steps hold last counter values.
REQ-025 DONE (one cycle): done=1; next IDLE; results and timeout held until next accepted start.
REQ-026 busy=1 in LOAD, RUN, PERIOD, DONE; 0 in IDLE.
REQ-027 Counters SHALL not wrap; MAX_STEPS bounds them (MAX_STEPS <= 2^CNT_W-1).
REQ-028 Simultaneous match and MAX_STEPS: match SHALL win, timeout=0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and all outputs 0 (init_state, meet_steps, period, timeout included), mid-search included.
REQ-030 After reset release the first accepted start SHALL behave as from power-up; the node array is reinitialised by LOAD.

Structure
REQ-031 FSM state encoding and default CNT_W SHALL live in shared package gnr_pkg.
REQ-032 No sub-module; equality comparators and counters inline.

Verification
REQ-033 Bench models node array per REQ-018 with a chosen next-state function.
REQ-034 Identity next-state, init_vec=16'h00A5 -> match at t=2, meet_steps=1, period=1, timeout=0, done 1 cycle.
REQ-035 Next-state = (x+1) mod 3 on bits[1:0], init 0 -> period=3, meet_steps=3, start_s0 never high in PERIOD.
REQ-036 MAX_STEPS=8, cycle of length 20 -> timeout=1, done pulses, enables 0 from that cycle.
REQ-037 rst_n low during RUN t=5 -> all outputs 0 asynchronously, IDLE; fresh start completes normally.
REQ-038 start pulsed during RUN and PERIOD -> ignored; results identical to undisturbed run.

Source files
------------

// File: rtl/gnr_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gnr_pkg -- shared definitions for the cycle-detection controller.
//
// Contents:
//   GNR_CNT_W    default width of the step / period counters
//   gnr_state_e  controller FSM state encoding
//   is_busy()    true in every state except IDLE
// ---------------------------------------------------------------------------
package gnr_pkg;

  localparam int GNR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PERIOD = 3'd3,
    ST_DONE   = 3'd4
  } gnr_state_e;

  function automatic logic is_busy(input gnr_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/gnr_cycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// gnr_cycle_ctrl_if -- signal bundle between the cycle controller and the
// host / node array.
//
// Signals:
//   start       host -> ctrl   one-cycle search request (honoured in IDLE)
//   init_vec    host -> ctrl   initial network state, captured on start
//   s0_vec      nodes -> ctrl  slow-trajectory node states
//   s1_vec      nodes -> ctrl  fast-trajectory node states
//   reset_nos   ctrl -> nodes  load strobe (nodes take init_state)
//   init_state  ctrl -> nodes  per-node load value
//   start_s0    ctrl -> nodes  slow-trajectory advance enable
//   start_s1    ctrl -> nodes  fast-trajectory advance enable
//   busy, done, timeout, meet_steps, period   ctrl -> host status/results
//
// Modports: master = controller side, slave = host/node side.
// ---------------------------------------------------------------------------
interface gnr_cycle_ctrl_if
  import gnr_pkg::*;
#(
  parameter int N_NODES = 16,
  parameter int CNT_W   = GNR_CNT_W
);

  logic               start;
  logic [N_NODES-1:0] init_vec;
  logic [N_NODES-1:0] s0_vec;
  logic [N_NODES-1:0] s1_vec;

  logic               reset_nos;
  logic [N_NODES-1:0] init_state;
  logic               start_s0;
  logic               start_s1;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   meet_steps;
  logic [CNT_W-1:0]   period;

  modport master (
    input  start, init_vec, s0_vec, s1_vec,
    output reset_nos, init_state, start_s0, start_s1,
           busy, done, timeout, meet_steps, period
  );

  modport slave (
    output start, init_vec, s0_vec, s1_vec,
    input  reset_nos, init_state, start_s0, start_s1,
           busy, done, timeout, meet_steps, period
  );

endinterface

// File: rtl/gnr_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// gnr_cycle_ctrl -- Floyd-style attractor finder for a network of nodes.
//
// The node array runs two copies of the network: a slow trajectory (s0) that
// advances one step every second enabled cycle, and a fast trajectory (s1)
// that advances every enabled cycle. The controller loads both copies with
// init_vec, runs them until they coincide (meeting point), then freezes the
// slow copy and counts fast steps until they coincide again (attractor
// period).
//
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    gnr_cycle_ctrl_if.master (handshake, node control, results)
//
// Parameters:
//   N_NODES    number of nodes (width of the state vectors)
//   CNT_W      width of the step / period counters
//   MAX_STEPS  RUN / PERIOD cycle limit before timeout (<= 2^CNT_W-1)
// ---------------------------------------------------------------------------
module gnr_cycle_ctrl
  import gnr_pkg::*;
#(
  parameter int          N_NODES   = 16,
  parameter int          CNT_W     = GNR_CNT_W,
  parameter int unsigned MAX_STEPS = 32'h0000_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gnr_cycle_ctrl_if.master      bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  gnr_state_e         state_q, state_d;
  logic [CNT_W-1:0]   t_q, t_d;            // RUN cycles elapsed
  logic [CNT_W-1:0]   p_q, p_d;            // PERIOD cycles elapsed
  logic [N_NODES-1:0] init_q, init_d;
  logic [CNT_W-1:0]   meet_q, meet_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               timeout_q, timeout_d;

  logic vec_eq;
  logic run_match;
  logic per_match;
  logic reset_nos;
  logic en_s0;
  logic en_s1;
  logic done;

  assign vec_eq    = (bus.s0_vec == bus.s1_vec);
  // Only even t gives the slow copy exactly t/2 steps; t=0 is the trivial
  // coincidence straight after the load.
  assign run_match = (t_q != '0) && !t_q[0] && vec_eq;
  // p=0 is the meeting point itself, so it cannot count as a return.
  assign per_match = (p_q != '0) && vec_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      p_q       <= '0;
      init_q    <= '0;
      meet_q    <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      p_q       <= p_d;
      init_q    <= init_d;
      meet_q    <= meet_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    p_d       = p_q;
    init_d    = init_q;
    meet_d    = meet_q;
    period_d  = period_q;
    timeout_d = timeout_q;
    reset_nos = 1'b0;
    en_s0     = 1'b0;
    en_s1     = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          init_d    = bus.init_vec;
          t_d       = '0;
          p_d       = '0;
          meet_d    = '0;
          period_d  = '0;
          timeout_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        reset_nos = 1'b1;
        t_d       = '0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // A match on the limit cycle still counts as a match.
        if (run_match) begin
          meet_d  = t_q >> 1;
          p_d     = '0;
          state_d = ST_PERIOD;
        end else if (t_q == MAX_CNT) begin
          // Report how far the slow trajectory got before giving up.
          timeout_d = 1'b1;
          meet_d    = t_q >> 1;
          state_d   = ST_DONE;
        end else begin
          en_s0 = 1'b1;
          en_s1 = 1'b1;
          t_d   = t_q + ONE;
        end
      end

      ST_PERIOD: begin
        if (per_match) begin
          period_d = p_q;
          state_d  = ST_DONE;
        end else if (p_q == MAX_CNT) begin
          timeout_d = 1'b1;
          period_d  = p_q;
          state_d   = ST_DONE;
        end else begin
          en_s1 = 1'b1;
          p_d   = p_q + ONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.reset_nos  = reset_nos;
  assign bus.init_state = init_q;
  assign bus.start_s0   = en_s0;
  assign bus.start_s1   = en_s1;
  assign bus.busy       = is_busy(state_q);
  assign bus.done       = done;
  assign bus.timeout    = timeout_q;
  assign bus.meet_steps = meet_q;
  assign bus.period     = period_q;

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gnr_cycle_ctrl -- self-checking bench for gnr_cycle_ctrl.
// Two controllers: dut_a (default limit) and dut_b (MAX_STEPS=8), each with a
// behavioural node array whose next-state function is selectable.
// ---------------------------------------------------------------------------
module tb_gnr_cycle_ctrl;
  import gnr_pkg::*;

  localparam int F_ID    = 0;
  localparam int F_MOD3  = 1;
  localparam int F_MOD4  = 2;
  localparam int F_MOD20 = 3;
  localparam int F_RHO   = 4;   // 0,1,2 tail then 3..7 loop

  logic clk;
  logic rst_n;

  gnr_cycle_ctrl_if #(.N_NODES(16), .CNT_W(16)) bus_a ();
  gnr_cycle_ctrl_if #(.N_NODES(16), .CNT_W(16)) bus_b ();

  gnr_cycle_ctrl #(.N_NODES(16), .CNT_W(16), .MAX_STEPS(32'h0000_FFFF)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gnr_cycle_ctrl #(.N_NODES(16), .CNT_W(16), .MAX_STEPS(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // ---------------- node array models ----------------
  function automatic logic [15:0] nxt(input int mode, input logic [15:0] x);
    logic [15:0] y;
    y = x;
    case (mode)
      F_MOD3:  y[1:0] = (x[1:0] == 2'd2) ? 2'd0 : x[1:0] + 2'd1;
      F_MOD4:  y[1:0] = x[1:0] + 2'd1;
      F_MOD20: y[4:0] = (x[4:0] == 5'd19) ? 5'd0 : x[4:0] + 5'd1;
      F_RHO:   y[3:0] = (x[3:0] == 4'd7) ? 4'd3 : x[3:0] + 4'd1;
      default: y = x;
    endcase
    return y;
  endfunction

  int          mode_a, mode_b;
  logic [15:0] s0a, s1a, s0b, s1b;
  logic        toga, togb;

  always_ff @(posedge clk) begin
    if (bus_a.reset_nos) begin
      s0a  <= bus_a.init_state;
      s1a  <= bus_a.init_state;
      toga <= 1'b0;
    end else begin
      if (bus_a.start_s1) s1a <= nxt(mode_a, s1a);
      if (bus_a.start_s0) begin
        toga <= ~toga;
        if (toga) s0a <= nxt(mode_a, s0a);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus_b.reset_nos) begin
      s0b  <= bus_b.init_state;
      s1b  <= bus_b.init_state;
      togb <= 1'b0;
    end else begin
      if (bus_b.start_s1) s1b <= nxt(mode_b, s1b);
      if (bus_b.start_s0) begin
        togb <= ~togb;
        if (togb) s0b <= nxt(mode_b, s0b);
      end
    end
  end

  assign bus_a.s0_vec = s0a;
  assign bus_a.s1_vec = s1a;
  assign bus_b.s0_vec = s0b;
  assign bus_b.s1_vec = s1b;

  // ---------------- observation mux ----------------
  int          sel;
  logic        o_busy, o_done, o_to, o_rn, o_e0, o_e1;
  logic [15:0] o_meet, o_per, o_init;

  always_comb begin
    o_busy = bus_a.busy;     o_done = bus_a.done;     o_to   = bus_a.timeout;
    o_rn   = bus_a.reset_nos; o_e0  = bus_a.start_s0; o_e1   = bus_a.start_s1;
    o_meet = bus_a.meet_steps; o_per = bus_a.period;  o_init = bus_a.init_state;
    if (sel == 1) begin
      o_busy = bus_b.busy;     o_done = bus_b.done;     o_to   = bus_b.timeout;
      o_rn   = bus_b.reset_nos; o_e0  = bus_b.start_s0; o_e1   = bus_b.start_s1;
      o_meet = bus_b.meet_steps; o_per = bus_b.period;  o_init = bus_b.init_state;
    end
  end

  // ---------------- checking ----------------
  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic drive(input logic st, input logic [15:0] iv);
    if (sel == 1) begin
      bus_b.start    = st;
      bus_b.init_vec = iv;
    end else begin
      bus_a.start    = st;
      bus_a.init_vec = iv;
    end
  endtask

  typedef struct {
    int          d;      // 0 = dut_a, 1 = dut_b
    int          mode;
    logic [15:0] init;
    int          meet;
    int          per;
    bit          tmo;
    int          cyc;    // edges from start acceptance to DONE
  } vec_t;

  vec_t tbl[9];

  // Runs one search; g1/g2 are sample indices at which a stray start is
  // pulsed (negative = none).
  task automatic run_one(input vec_t v, input int g1, input int g2);
    int done_at, n_busy, n_s0, n_s1;
    done_at = -1; n_busy = 0; n_s0 = 0; n_s1 = 0;
    sel = v.d;
    if (v.d == 1) mode_b = v.mode; else mode_a = v.mode;
    @(negedge clk);
    drive(1'b1, v.init);
    @(negedge clk);
    drive(1'b0, 16'hDEAD);
    // LOAD cycle
    chk("load_reset_nos", o_rn, 1);
    chk("load_enables", {o_e0, o_e1}, 0);
    chk("load_timeout_clr", o_to, 0);
    chk("load_meet_clr", o_meet, 0);
    chk("load_period_clr", o_per, 0);
    chk("load_init_state", o_init, v.init);
    for (int c = 0; c < 200 && done_at < 0; c++) begin
      if (o_busy) n_busy++;
      if (o_e0)   n_s0++;
      if (o_e1)   n_s1++;
      if (o_done) done_at = c;
      drive((c == g1) || (c == g2), 16'hDEAD);
      @(negedge clk);
    end
    chk("done_seen", (done_at >= 0), 1);
    chk("done_cycle", done_at, v.cyc);
    chk("done_pulse_width", o_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("busy_cycles", n_busy, v.cyc + 1);
    chk("start_s0_count", n_s0, 2 * v.meet);
    chk("start_s1_count", n_s1, 2 * v.meet + v.per);
    chk("meet_steps", o_meet, v.meet);
    chk("period", o_per, v.per);
    chk("timeout", o_to, v.tmo);
    chk("init_state_kept", o_init, v.init);
    repeat (3) @(negedge clk);
    chk("meet_held", o_meet, v.meet);
    chk("timeout_held", o_to, v.tmo);
    $display("run dut=%0d mode=%0d init=%h: meet=%0d period=%0d timeout=%0d done_at=%0d",
             v.d, v.mode, v.init, o_meet, o_per, o_to, done_at);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    clk = 1'b0; rst_n = 1'b0; sel = 0;
    mode_a = F_ID; mode_b = F_ID;
    bus_a.start = 1'b0; bus_a.init_vec = '0;
    bus_b.start = 1'b0; bus_b.init_vec = '0;

    //            d  mode     init      meet per tmo  cyc
    tbl[0] = '{0, F_ID,    16'h00A5,  1,  1, 1'b0,  6};
    tbl[1] = '{0, F_MOD3,  16'h0000,  3,  3, 1'b0, 12};
    tbl[2] = '{0, F_RHO,   16'h00F0,  5,  5, 1'b0, 18};
    tbl[3] = '{0, F_MOD4,  16'h0000,  4,  4, 1'b0, 15};
    tbl[4] = '{1, F_MOD20, 16'h0000,  4,  0, 1'b1, 10};
    tbl[5] = '{1, F_MOD4,  16'h0000,  4,  4, 1'b0, 15};  // match on limit
    tbl[6] = '{1, F_ID,    16'h1234,  1,  1, 1'b0,  6};
    tbl[7] = '{1, F_RHO,   16'h00F0,  4,  0, 1'b1, 10};
    tbl[8] = '{0, F_MOD20, 16'h0000, 20, 20, 1'b0, 63};

    // reset state
    #12;
    chk("rst_busy_a", bus_a.busy, 0);
    chk("rst_init_a", bus_a.init_state, 0);
    chk("rst_meet_b", bus_b.meet_steps, 0);
    chk("rst_timeout_b", bus_b.timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", bus_a.busy, 0);

    for (int i = 0; i < 9; i++) run_one(tbl[i], -1, -1);

    // reset clears held results (dut_a holds meet=20 period=20)
    sel = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_clr_meet", o_meet, 0);
    chk("rst_clr_period", o_per, 0);
    chk("rst_clr_init", o_init, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset asserted asynchronously in RUN at t=5
    mode_a = F_MOD20;
    @(negedge clk);
    drive(1'b1, 16'h0003);
    @(negedge clk);
    drive(1'b0, 16'hDEAD);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", o_busy, 1);
    chk("pre_rst_en", {o_e0, o_e1}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", o_busy, 0);
    chk("async_en", {o_e0, o_e1}, 0);
    chk("async_rn_done", {o_rn, o_done}, 0);
    chk("async_init", o_init, 0);
    chk("async_results", {o_meet, o_per}, 0);
    chk("async_timeout", o_to, 0);
    @(negedge clk);
    chk("held_idle", o_busy, 0);
    rst_n = 1'b1;
    run_one(tbl[2], -1, -1);

    // stray starts in RUN (sample 4) and PERIOD (sample 14) are ignored
    run_one(tbl[2], 4, 14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
